mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, 4, consecutive data grants allowed while fetch waits (1..15).
REQ-002 Ports, in this order (name, direction, width, meaning):
- clk, in, 1, single clock; all state changes on the rising edge.
- rst, in, 1, reset; synchronous, active-high.
- if_req, in, 1, instruction-fetch request.
- if_addr, in, 32, fetch address.
- if_gnt, out, 1, fetch granted.
- if_valid, out, 1, fetch data valid (one-cycle pulse).
- if_rdata, out, 32, fetch data.
- d_req, in, 1, load/store request.
- d_we, in, 1, 1 = store (DataCacheWrite), 0 = load (DataCacheRead).
- d_addr, in, 32, data address.
- d_wdata, in, 32, store data.
- d_gnt, out, 1, data granted.
- d_valid, out, 1, data access complete (one-cycle pulse).
- d_rdata, out, 32, load data.
- mem_req, out, 1, memory request.
- mem_we, out, 1, memory write enable.
- mem_addr, out, 32, memory address.
- mem_wdata, out, 32, memory write data.
- mem_ack, in, 1, memory completion.
- mem_rdata, in, 32, memory read data.
- stall_if, out, 1, hold IF_ID.

Function
REQ-003 The FSM SHALL have three states: IDLE, BUSY_I and BUSY_D.
REQ-004 In IDLE, gnt SHALL be combinational, in the same cycle: d_gnt = d_req; if_gnt = if_req & ~d_req. Data has priority unless overridden by REQ-017.
REQ-005 On a grant, the edge SHALL latch addr, we and wdata and move to BUSY_D or BUSY_I. A fetch SHALL latch mem_we = 0 and mem_wdata = 0.
REQ-006 mem_req SHALL be registered: high from the cycle after the grant, held through the cycle mem_ack = 1 inclusive.
REQ-007 The mem_addr, mem_we and mem_wdata outputs SHALL stay stable while mem_req = 1.
REQ-008 On mem_ack = 1 in BUSY_x, the edge SHALL:
- return the FSM to IDLE;
- drop mem_req;
- pulse x_valid for exactly one cycle.
REQ-009 On a read ack, x_rdata SHALL capture mem_rdata. d_rdata SHALL hold its value on a store ack.
REQ-010 No gnt SHALL be issued in BUSY_I or BUSY_D. Only one transaction SHALL be outstanding.
REQ-011 Minimum latency:
- req at cycle N;
- mem_req at N+1;
- ack at N+1;
- valid at N+2;
- next grant possible at N+2.
REQ-012 mem_ack in IDLE SHALL be ignored; no valid pulse and no state change.
REQ-013 Requesters SHALL hold req, addr, we and wdata until gnt. req may drop after gnt. A req held after valid SHALL be treated as a new request.
REQ-014 stall_if SHALL equal if_req & ~if_gnt & ~if_valid.
REQ-015 If if_req and d_req rise simultaneously in IDLE, exactly one gnt SHALL be high, per REQ-004/REQ-017.

Reset
REQ-016 On rst = 1 at an edge:
- state SHALL go to IDLE;
- mem_req, mem_we, if_valid and d_valid SHALL be 0;
- mem_addr, mem_wdata, if_rdata and d_rdata SHALL be 0;
- the starvation counter SHALL be 0.
A transaction in flight SHALL be abandoned, with no valid pulse. A mem_ack arriving after reset SHALL be ignored per REQ-012. While rst = 1, gnt outputs SHALL be 0.

Configuration
REQ-017 With ARB_STARVE_GUARD_EN defined:
- a 4-bit counter SHALL increment on each d_gnt while if_req = 1;
- it SHALL clear on if_gnt or when if_req = 0;
- when count == STARVE_LIMIT, IDLE arbitration SHALL grant fetch (if_gnt = if_req, d_gnt = 0).
REQ-018 Without ARB_STARVE_GUARD_EN, strict data priority SHALL apply and no counter SHALL exist.

Verification
REQ-019 Single fetch: if_req at N, if_addr = 0x100; mem_rdata = 0x00500093 with ack at N+3 -> if_gnt at N; mem_req N+1..N+3; if_valid at N+4; if_rdata = 0x00500093.
REQ-020 Simultaneous requests: if_req = d_req = 1 at N; d_we = 1, d_addr = 0x2000, d_wdata = 0xDEADBEEF -> d_gnt at N; mem_we = 1 and mem_wdata = 0xDEADBEEF; d_valid after ack; then if_gnt in the d_valid cycle.
REQ-021 Reset mid-op: rst at N+1 during BUSY_D, then mem_ack at N+2 -> mem_req = 0 from N+2; no d_valid; FSM in IDLE.
REQ-022 Stray ack: mem_ack = 1 in IDLE, mem_rdata = 0xFFFFFFFF -> no valid pulse; rdata unchanged.
REQ-023 Starvation, ARB_STARVE_GUARD_EN with STARVE_LIMIT = 4: d_req and if_req held high -> four data grants, the fifth grant to fetch. Without the macro -> data only; stall_if stays 1.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and data
// (load/store) requesters. One transaction in flight at a time.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   if_req/if_addr            fetch request; if_gnt, if_valid, if_rdata back
//   d_req/d_we/d_addr/d_wdata data request; d_gnt, d_valid, d_rdata back
//   mem_req/mem_we/mem_addr/mem_wdata  registered memory request
//   mem_ack/mem_rdata         memory completion and read data
//   stall_if                  hold IF_ID while a fetch is waiting
//
// Parameter STARVE_LIMIT (1..15): consecutive data grants tolerated while fetch waits.
// Optional macro ARB_STARVE_GUARD_EN: enables the fetch starvation guard; without it,
// data has strict priority.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_valid,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall_if
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("STARVE_LIMIT must be in 1..15");
  end

  typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

  state_e      state_q, state_d;
  logic        mem_req_q, mem_we_q;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic        if_valid_q, d_valid_q;
  logic [31:0] if_rdata_q, d_rdata_q;
  logic        starve;

`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] starve_cnt_q, starve_cnt_d;

  assign starve = (starve_cnt_q == 4'(STARVE_LIMIT));

  // Counts data grants taken while fetch is waiting; any fetch grant or an
  // idle fetch requester resets the count.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!if_req || if_gnt) begin
      starve_cnt_d = 4'd0;
    end else if (d_gnt) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= 4'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  assign starve = 1'b0;
`endif

  // Grants are combinational and only ever issued from idle.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (!rst && state_q == StIdle) begin
      if (starve) begin
        if_gnt = if_req;
      end else begin
        d_gnt  = d_req;
        if_gnt = if_req & ~d_req;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (d_gnt) begin
          state_d = StBusyD;
        end else if (if_gnt) begin
          state_d = StBusyI;
        end
      end
      StBusyI, StBusyD: begin
        if (mem_ack) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      if_rdata_q  <= 32'd0;
      d_rdata_q   <= 32'd0;
    end else begin
      state_q    <= state_d;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      if (state_q == StIdle) begin
        // An ack seen in idle is stray and deliberately ignored.
        if (d_gnt) begin
          mem_req_q   <= 1'b1;
          mem_we_q    <= d_we;
          mem_addr_q  <= d_addr;
          mem_wdata_q <= d_wdata;
        end else if (if_gnt) begin
          mem_req_q   <= 1'b1;
          mem_we_q    <= 1'b0;
          mem_addr_q  <= if_addr;
          mem_wdata_q <= 32'd0;
        end
      end else if (mem_ack) begin
        mem_req_q <= 1'b0;
        if (state_q == StBusyI) begin
          if_valid_q <= 1'b1;
          if_rdata_q <= mem_rdata;
        end else begin
          d_valid_q <= 1'b1;
          if (!mem_we_q) begin
            d_rdata_q <= mem_rdata;
          end
        end
      end
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_valid  = if_valid_q;
  assign d_valid   = d_valid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign stall_if  = if_req & ~if_gnt & ~if_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized + directed bench for mem_port_arbiter. A transaction-level model
// predicts grants and completions; expected memory requests and responses go
// into scoreboard queues that a separate monitor drains.
module tb_mem_port_arbiter;

  localparam int unsigned Limit = 4;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit Guard = 1'b1;
`else
  localparam bit Guard = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, if_req, d_req, d_we, mem_ack;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic if_gnt, if_valid, d_gnt, d_valid, mem_req, mem_we, stall_if;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIMIT(Limit)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid),
    .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall_if(stall_if)
  );

  typedef struct packed {logic port; logic [31:0] data;} resp_t;  // port 1 = data
  typedef struct packed {logic we; logic [31:0] addr; logic [31:0] wdata;} mtx_t;

  resp_t resp_q[$];
  mtx_t  mem_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Stimulus controls
  bit          if_pend, d_pend, rand_reqs, auto_refill, stray, use_fixed, rst_req;
  int          ack_mode;  // 0 random, 1 never, 2 always
  logic [31:0] fixed_data;

  // Reference model state
  bit          m_busy, m_port, m_we, m_if_valid, m_d_valid;
  int          m_cnt;
  logic [31:0] m_if_rdata, m_d_rdata;

  // Starvation observation
  int dgrants_before_fetch;
  bit seen_fetch, stall_all;

  task automatic step();
    bit exp_dg, exp_ig, starve, nv_if, nv_d;
    @(negedge clk);
    if (auto_refill) begin
      if (!if_pend) begin if_pend = 1; if_addr = $urandom & 32'hFFFF_FFFC; end
      if (!d_pend) begin
        d_pend = 1; d_we = 1'($urandom); d_addr = $urandom & 32'hFFFF_FFFC; d_wdata = $urandom;
      end
    end else if (rand_reqs) begin
      if (!if_pend && $urandom_range(0, 2) == 0) begin
        if_pend = 1; if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!d_pend && $urandom_range(0, 2) == 0) begin
        d_pend = 1; d_we = 1'($urandom); d_addr = $urandom & 32'hFFFF_FFFC; d_wdata = $urandom;
      end
    end
    rst    = rst_req;
    if_req = if_pend;
    d_req  = d_pend;
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    if (m_busy) begin
      if (ack_mode == 0) mem_ack = ($urandom_range(0, 2) == 0);
      else if (ack_mode == 2) mem_ack = 1'b1;
    end else if (stray) begin
      mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    end else if (ack_mode == 0 && $urandom_range(0, 7) == 0) begin
      mem_ack = 1'b1;
    end
    if (use_fixed) mem_rdata = fixed_data;
    #1;
    exp_dg = 0; exp_ig = 0;
    starve = Guard && (m_cnt == int'(Limit));
    if (!rst && !m_busy) begin
      if (starve) exp_ig = if_req;
      else begin exp_dg = d_req; exp_ig = if_req && !d_req; end
    end
    check("d_gnt", 32'(d_gnt), 32'(exp_dg));
    check("if_gnt", 32'(if_gnt), 32'(exp_ig));
    check("if_valid", 32'(if_valid), 32'(m_if_valid));
    check("d_valid", 32'(d_valid), 32'(m_d_valid));
    check("mem_req", 32'(mem_req), 32'(m_busy));
    check("if_rdata_hold", if_rdata, m_if_rdata);
    check("d_rdata_hold", d_rdata, m_d_rdata);
    check("stall_if", 32'(stall_if), 32'(if_req && !exp_ig && !m_if_valid));
    if (d_gnt && !seen_fetch) dgrants_before_fetch++;
    if (if_gnt) seen_fetch = 1;
    if (stall_if !== 1'b1) stall_all = 0;
    // Model update for the coming edge
    nv_if = 0; nv_d = 0;
    if (rst) begin
      m_busy = 0; m_cnt = 0; m_if_rdata = 0; m_d_rdata = 0;
    end else begin
      if (m_busy && mem_ack) begin
        if (!m_port) begin
          m_if_rdata = mem_rdata; nv_if = 1; resp_q.push_back('{1'b0, mem_rdata});
        end else begin
          if (!m_we) m_d_rdata = mem_rdata;
          nv_d = 1; resp_q.push_back('{1'b1, m_d_rdata});
        end
        m_busy = 0;
      end else if (exp_dg) begin
        m_busy = 1; m_port = 1; m_we = d_we;
        mem_q.push_back('{d_we, d_addr, d_wdata});
        d_pend = 0;
      end else if (exp_ig) begin
        m_busy = 1; m_port = 0; m_we = 0;
        mem_q.push_back('{1'b0, if_addr, 32'd0});
        if_pend = 0;
      end
      if (Guard) begin
        if (!if_req || exp_ig) m_cnt = 0;
        else if (exp_dg) m_cnt++;
      end
    end
    m_if_valid = nv_if; m_d_valid = nv_d;
  endtask

  task automatic drain();
    rand_reqs = 0; auto_refill = 0; ack_mode = 2; stray = 0; use_fixed = 0;
    for (int i = 0; i < 12; i++) step();
  endtask

  // Monitor: pops scoreboard queues whenever the DUT presents a response or a new request.
  bit mon_en = 0;
  logic prev_req = 1'b0;
  mtx_t held;
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        if (if_valid === 1'b1 || d_valid === 1'b1) begin
          if (resp_q.size() == 0) begin
            check("resp_unexpected", {31'd0, d_valid}, 32'hFFFF_FFFF);
          end else begin
            e = resp_q.pop_front();
            check("resp_port", 32'(d_valid), 32'(e.port));
            check("resp_rdata", e.port ? d_rdata : if_rdata, e.data);
          end
        end
        if (mem_req === 1'b1 && prev_req !== 1'b1) begin
          if (mem_q.size() == 0) begin
            check("mem_unexpected", mem_addr, ~mem_addr);
          end else begin
            held = mem_q.pop_front();
            check("mem_we", 32'(mem_we), 32'(held.we));
            check("mem_addr", mem_addr, held.addr);
            check("mem_wdata", mem_wdata, held.wdata);
          end
        end else if (mem_req === 1'b1) begin
          check("mem_stable", {mem_addr ^ held.addr} | {mem_wdata ^ held.wdata}
                              | 32'(mem_we ^ held.we), 32'd0);
        end
        prev_req = mem_req;
      end
    end
  end

  initial begin
    rst = 1; if_req = 0; d_req = 0; d_we = 0; mem_ack = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
    if_pend = 0; d_pend = 0; rand_reqs = 0; auto_refill = 0; stray = 0;
    use_fixed = 0; rst_req = 0; ack_mode = 1; fixed_data = 0;
    m_busy = 0; m_port = 0; m_we = 0; m_if_valid = 0; m_d_valid = 0; m_cnt = 0;
    m_if_rdata = 0; m_d_rdata = 0;
    dgrants_before_fetch = 0; seen_fetch = 0; stall_all = 1;
    repeat (3) @(posedge clk);
    mon_en = 1;
    rst_req = 1; step();            // reset state checked by the model
    rst_req = 0; step();

    // Single fetch, ack three cycles after the request
    if_pend = 1; if_addr = 32'h100;
    step();                          // grant
    step(); step();                  // waiting
    ack_mode = 2; use_fixed = 1; fixed_data = 32'h0050_0093;
    step();                          // ack
    ack_mode = 1; use_fixed = 0;
    step();                          // valid
    check("single_fetch_rdata", if_rdata, 32'h0050_0093);

    // Simultaneous requests: store wins, fetch granted in the d_valid cycle
    if_pend = 1; if_addr = 32'h104;
    d_pend = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF;
    ack_mode = 2;
    for (int i = 0; i < 5; i++) step();
    drain();

    // Stray ack in idle
    stray = 1; step(); stray = 0; step();

    // Reset mid-operation, then ack arriving after reset
    d_pend = 1; d_we = 1; d_addr = 32'h3000; d_wdata = 32'h1234_5678; ack_mode = 1;
    step();                          // grant
    rst_req = 1; step(); rst_req = 0;
    stray = 1; step(); stray = 0;
    step();

    // Starvation with both requesters always asking
    dgrants_before_fetch = 0; seen_fetch = 0; stall_all = 1;
    auto_refill = 1; ack_mode = 2;
    for (int i = 0; i < 20; i++) step();
    if (Guard) begin
      check("starve_data_grants", dgrants_before_fetch, Limit);
      check("starve_fetch_seen", 32'(seen_fetch), 32'd1);
    end else begin
      check("no_guard_fetch_seen", 32'(seen_fetch), 32'd0);
      check("no_guard_stall", 32'(stall_all), 32'd1);
    end
    auto_refill = 0;
    drain();
    if_pend = 0; d_pend = 0;
    drain();

    // Randomized traffic
    rand_reqs = 1; ack_mode = 0;
    for (int i = 0; i < 2000; i++) begin
      rst_req = ($urandom_range(0, 199) == 0);
      step();
    end
    rst_req = 0;
    drain();
    if_pend = 0; d_pend = 0;
    drain();
    check("resp_queue_empty", resp_q.size(), 0);
    check("mem_queue_empty", mem_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
